vga_fb_arbiter: RTL

Single-port framebuffer arbiter between the VGA scan-out reader, a bulk clear engine and a pixel-write client. It sits between the VGA timing/colour path and one synchronous single-port RAM. Scan-out reads always win so pixel latency stays fixed. The clear engine fills the whole buffer with one colour using free cycles, and the write client gets whatever bandwidth remains, under a valid/ready handshake.

---
 rtl/vga_fb_arbiter_if.sv | 42 ++++
 rtl/vga_fb_arbiter.sv | 81 ++++++++
 2 files changed

// File: rtl/vga_fb_arbiter_if.sv
// vga_fb_arbiter_if: bundle of every framebuffer arbiter signal.
// Ports (by group): scan-out disp_req/disp_addr -> disp_data/disp_valid;
// writer wr_valid/wr_addr/wr_data -> wr_ready; clear clear_start/clear_color
// -> clear_busy/clear_done; stall_cnt status; RAM mem_en/mem_we/mem_addr/
// mem_wdata <- mem_rdata. The slave modport is the arbiter, master the rest.
interface vga_fb_arbiter_if #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 15
);
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic [DATA_W-1:0] disp_data;
    logic              disp_valid;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              clear_start;
    logic [DATA_W-1:0] clear_color;
    logic              clear_busy;
    logic              clear_done;
    logic [15:0]       stall_cnt;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  disp_req, disp_addr, wr_valid, wr_addr, wr_data,
               clear_start, clear_color, mem_rdata,
        output disp_data, disp_valid, wr_ready, clear_busy, clear_done,
               stall_cnt, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output disp_req, disp_addr, wr_valid, wr_addr, wr_data,
               clear_start, clear_color, mem_rdata,
        input  disp_data, disp_valid, wr_ready, clear_busy, clear_done,
               stall_cnt, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: single-port framebuffer arbiter, display > clear > writer.
// Ports: CLK_I clock, reset async active-low, bus (slave modport) carrying
// the scan-out read port, pixel writer handshake, clear engine control,
// stall counter and the single-port RAM interface.
module vga_fb_arbiter #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 15,
    parameter int DEPTH  = 19200
) (
    input logic            CLK_I,
    input logic            reset,
    vga_fb_arbiter_if.slave bus
);
    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic [DATA_W-1:0] color_q, color_d;
    logic              disp_valid_q, disp_valid_d;
    logic              clear_done_q, clear_done_d;
    logic [15:0]       stall_q, stall_d;
    logic              ready, clr_wr, wr_go, disp_go;

    always_comb begin
        // Grants are gated by reset so the RAM port stays quiet while held in reset.
        disp_go      = reset && bus.disp_req;
        ready        = reset && state_q == IDLE && !bus.clear_start && !bus.disp_req;
        clr_wr       = reset && state_q == CLEAR && !bus.disp_req;
        wr_go        = ready && bus.wr_valid;
        state_d      = state_q;
        clr_addr_d   = clr_addr_q;
        color_d      = color_q;
        clear_done_d = 1'b0;
        disp_valid_d = bus.disp_req;
        if (state_q == IDLE && bus.clear_start) begin
            state_d    = CLEAR;
            clr_addr_d = '0;
            color_d    = bus.clear_color;
        end
        if (clr_wr) begin
            if (clr_addr_q == LAST) begin
                state_d      = IDLE;
                clear_done_d = 1'b1;
            end else begin
                clr_addr_d = clr_addr_q + 1'b1;
            end
        end
        stall_d = stall_q + {15'd0, bus.wr_valid && !ready && stall_q != 16'hFFFF};
    end

    always_ff @(posedge CLK_I or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            clr_addr_q   <= '0;
            color_q      <= '0;
            disp_valid_q <= 1'b0;
            clear_done_q <= 1'b0;
            stall_q      <= '0;
        end else begin
            state_q      <= state_d;
            clr_addr_q   <= clr_addr_d;
            color_q      <= color_d;
            disp_valid_q <= disp_valid_d;
            clear_done_q <= clear_done_d;
            stall_q      <= stall_d;
        end
    end

    assign bus.mem_en     = disp_go || clr_wr || wr_go;
    assign bus.mem_we     = clr_wr || wr_go;
    assign bus.mem_addr   = disp_go ? bus.disp_addr : clr_wr ? clr_addr_q : wr_go ? bus.wr_addr : '0;
    assign bus.mem_wdata  = clr_wr ? color_q : wr_go ? bus.wr_data : '0;
    assign bus.wr_ready   = ready;
    assign bus.disp_data  = bus.mem_rdata;
    assign bus.disp_valid = disp_valid_q;
    assign bus.clear_busy = state_q == CLEAR;
    assign bus.clear_done = clear_done_q;
    assign bus.stall_cnt  = stall_q;
endmodule
